// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Load/store access controller driving one port of the on-chip RAM.
// Byte-addressed core requests (valid/ready) become word-addressed RAM cycles
// with byte write masks. Load data is realigned and sign/zero-extended. Every
// accepted request produces exactly one single-cycle rsp_valid pulse.
//
// Build option: RAM_ACC_MISALIGN_EN
//   defined   - halfwords at offset 3 and words at offset 1..3 are split into
//               two RAM accesses (ACC2/WAIT2 path)
//   undefined - misaligned halfword/word requests are rejected with rsp_err
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               core request channel (valid/ready handshake)
//   rsp_valid/rdata/err response pulse, extended load data, reject flag
//   ram_en/we/wem/addr/din  registered RAM port controls
//   ram_dout            RAM read data, valid the cycle after a read enable
module ram_access_ctrl #(
  parameter int unsigned RAM_DEPTH = 2048
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [31:0]                  req_addr,
  input  logic [1:0]                   req_size,
  input  logic                         req_unsigned,
  input  logic [31:0]                  req_wdata,
  output logic                         rsp_valid,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_err,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [3:0]                   ram_wem,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
  output logic [31:0]                  ram_din,
  input  logic [31:0]                  ram_dout
);
  // Same width as clogb2(RAM_DEPTH-1) for any RAM_DEPTH >= 2.
  localparam int unsigned AW = $clog2(RAM_DEPTH);

  typedef enum logic [2:0] {IDLE, ACC1, WAIT1, ACC2, WAIT2, RESP} state_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [1:0] o);
    logic [63:0] t;
    t = {x, x} << {o, 3'b000};
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [1:0] o);
    logic [63:0] t;
    t = {x, x} >> {o, 3'b000};
    return t[31:0];
  endfunction

  // Byte lanes touched by a request, wrapping past lane 3.
  function automatic logic [3:0] lane_set(input logic [1:0] size, input logic [1:0] o);
    logic [3:0] b;
    logic [7:0] t;
    case (size)
      2'b00:   b = 4'b0001;
      2'b01:   b = 4'b0011;
      default: b = 4'b1111;
    endcase
    t = {b, b} << o;
    return t[7:4];
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] l);
    logic [31:0] b;
    b = '0;
    for (int unsigned i = 0; i < 4; i++) b[8*i +: 8] = {8{l[i]}};
    return b;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   return uns ? {24'b0, a[7:0]}  : {{24{a[7]}}, a[7:0]};
      2'b01:   return uns ? {16'b0, a[15:0]} : {{16{a[15]}}, a[15:0]};
      default: return a;
    endcase
  endfunction

  state_t      state, state_d;
  logic        xfer, acc_err;
  logic [1:0]  o_in;
  logic [29:0] w_in;
  logic [3:0]  lanes_in, first_in;

  logic        we_q, uns_q;
  logic [1:0]  size_q, o_q;
  logic [3:0]  lanes_q, first_q;
  logic [31:0] asm_q, asm_next, cap_mask, load_data;

  logic            ram_en_d, ram_we_d, rsp_valid_d, rsp_err_d;
  logic [3:0]      ram_wem_d;
  logic [AW-1:0]   ram_addr_d;
  logic [31:0]     ram_din_d, rsp_rdata_d;

  assign req_ready = !rst && (state == IDLE || state == RESP);
  assign xfer      = req_valid && req_ready;
  assign o_in      = req_addr[1:0];
  assign w_in      = req_addr[31:2];
  assign lanes_in  = lane_set(req_size, o_in);
  assign first_in  = lanes_in & (4'hF << o_in);
  assign lanes_q   = lane_set(size_q, o_q);
  assign first_q   = lanes_q & (4'hF << o_q);

`ifdef RAM_ACC_MISALIGN_EN
  logic       split_in, split_q;
  logic [3:0] second_q;
  assign split_in = (req_size == 2'b01 && o_in == 2'd3) ||
                    (req_size == 2'b10 && o_in != 2'd0);
  assign second_q = lanes_q & ~(4'hF << o_q);
  always_comb begin
    acc_err = (req_size == 2'b11) || ({2'b00, w_in} >= RAM_DEPTH) ||
              (split_in && ({2'b00, w_in} >= RAM_DEPTH - 1));
  end
`else
  logic misalign_err;
  assign misalign_err = (req_size == 2'b01 && o_in[0]) ||
                        (req_size == 2'b10 && o_in != 2'd0);
  always_comb begin
    acc_err = (req_size == 2'b11) || ({2'b00, w_in} >= RAM_DEPTH) || misalign_err;
  end
`endif

  // Lanes owned by the access whose read data is arriving this cycle.
  always_comb begin
    cap_mask = '0;
    if (state == WAIT1) cap_mask = lane_bits(first_q);
`ifdef RAM_ACC_MISALIGN_EN
    else if (state == WAIT2) cap_mask = lane_bits(second_q);
`endif
  end

  assign asm_next  = (asm_q & ~cap_mask) | (ram_dout & cap_mask);
  assign load_data = extend(rotr32(asm_next, o_q), size_q, uns_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, RESP: begin
        if (xfer) state_d = acc_err ? RESP : ACC1;
        else      state_d = IDLE;
      end
      ACC1: state_d = WAIT1;
`ifdef RAM_ACC_MISALIGN_EN
      WAIT1: state_d = split_q ? ACC2 : RESP;
      ACC2:  state_d = WAIT2;
      WAIT2: state_d = RESP;
`else
      WAIT1: state_d = RESP;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed on the state being entered.
  // ACC1 is entered only on a transfer, so it is driven from the live request.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_wem_d   = '0;
    ram_addr_d  = ram_addr;
    ram_din_d   = ram_din;
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    if (state_d == ACC1) begin
      ram_en_d   = 1'b1;
      ram_we_d   = req_we;
      ram_wem_d  = req_we ? first_in : 4'b0000;
      ram_addr_d = w_in[AW-1:0];
      ram_din_d  = rotl32(req_wdata, o_in);
    end
`ifdef RAM_ACC_MISALIGN_EN
    if (state_d == ACC2) begin
      ram_en_d   = 1'b1;
      ram_we_d   = we_q;
      ram_wem_d  = we_q ? second_q : 4'b0000;
      ram_addr_d = ram_addr + AW'(1);
    end
`endif
    if (state_d == RESP) begin
      if (state == IDLE || state == RESP) begin
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end else begin
        rsp_err_d   = 1'b0;
        rsp_rdata_d = we_q ? 32'h0 : load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_wem   <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      asm_q     <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      o_q       <= '0;
`ifdef RAM_ACC_MISALIGN_EN
      split_q   <= 1'b0;
`endif
    end else begin
      ram_en    <= ram_en_d;
      ram_we    <= ram_we_d;
      ram_wem   <= ram_wem_d;
      ram_addr  <= ram_addr_d;
      ram_din   <= ram_din_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      asm_q     <= asm_next;
      if (xfer) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        size_q <= req_size;
        o_q    <= o_in;
`ifdef RAM_ACC_MISALIGN_EN
        split_q <= split_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err, ram_en, ram_we;
  logic [31:0] rsp_rdata, ram_din;
  logic [31:0] ram_dout = '0;
  logic [3:0]  ram_wem;
  logic [10:0] ram_addr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_access_ctrl #(.RAM_DEPTH(2048)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM model: byte-masked write, one-cycle read latency.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          en;
    logic [10:0] a1;
    logic [3:0]  m1;
    logic [31:0] d1;
    logic [10:0] a2;
    logic [3:0]  m2;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  task automatic add(input vec_t v);
    vecs[nv] = v;
    nv++;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k, en, lat;
    logic seen;
    logic [10:0] a[2];
    logic [3:0]  m[2];
    logic [31:0] d[2];
    k = 0;
    while (!req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("v%0d ready", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    en = 0; lat = 0; seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (c > 1) @(negedge clk);
      if (ram_en) begin
        if (en < 2) begin a[en] = ram_addr; m[en] = ram_wem; d[en] = ram_din; end
        chk($sformatf("v%0d ram_we", idx), 32'(ram_we), 32'(v.we));
        en++;
      end
      if (rsp_valid) begin
        seen = 1'b1;
        lat = c;
      end
    end
    chk($sformatf("v%0d rsp_seen", idx), 32'(seen), 32'd1);
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d rdata", idx), rsp_rdata, v.rdata);
    chk($sformatf("v%0d err", idx), 32'(rsp_err), 32'(v.err));
    chk($sformatf("v%0d en_count", idx), 32'(en), 32'(v.en));
    if (v.en >= 1 && en >= 1) begin
      chk($sformatf("v%0d addr1", idx), 32'(a[0]), 32'(v.a1));
      chk($sformatf("v%0d wem1", idx), 32'(m[0]), 32'(v.m1));
      chk($sformatf("v%0d din1", idx), d[0], v.d1);
    end
    if (v.en >= 2 && en >= 2) begin
      chk($sformatf("v%0d addr2", idx), 32'(a[1]), 32'(v.a2));
      chk($sformatf("v%0d wem2", idx), 32'(m[1]), 32'(v.m2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ne, nr, blips;
    int en_cyc[4];
    int rsp_cyc[4];
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;

    //   we addr        sz uns wdata          rdata          err lat en a1    m1     d1             a2  m2
    add('{1, 32'h10,    2, 0, 32'h11223344, 32'h0,         0, 3, 1, 4,    4'hF, 32'h11223344, 0,  0});
    add('{0, 32'h12,    0, 0, 32'h0,        32'h22,        0, 3, 1, 4,    4'h0, 32'h0,        0,  0});
    add('{1, 32'h07,    0, 0, 32'h80,       32'h0,         0, 3, 1, 1,    4'h8, 32'h80000000, 0,  0});
    add('{0, 32'h07,    0, 0, 32'h0,        32'hFFFFFF80,  0, 3, 1, 1,    4'h0, 32'h0,        0,  0});
    add('{0, 32'h07,    0, 1, 32'h0,        32'h80,        0, 3, 1, 1,    4'h0, 32'h0,        0,  0});
    add('{1, 32'h22,    1, 0, 32'hBEEF,     32'h0,         0, 3, 1, 8,    4'hC, 32'hBEEF0000, 0,  0});
    add('{0, 32'h22,    1, 0, 32'h0,        32'hFFFFBEEF,  0, 3, 1, 8,    4'h0, 32'h0,        0,  0});
    add('{0, 32'h22,    1, 1, 32'h0,        32'h0000BEEF,  0, 3, 1, 8,    4'h0, 32'h0,        0,  0});
    add('{0, 32'h10,    2, 0, 32'h0,        32'h11223344,  0, 3, 1, 4,    4'h0, 32'h0,        0,  0});
    add('{0, 32'h10,    1, 0, 32'h0,        32'h00003344,  0, 3, 1, 4,    4'h0, 32'h0,        0,  0});
    add('{0, 32'h10,    3, 0, 32'h0,        32'h0,         1, 1, 0, 0,    4'h0, 32'h0,        0,  0});
    add('{0, 32'h2000,  2, 0, 32'h0,        32'h0,         1, 1, 0, 0,    4'h0, 32'h0,        0,  0});
    add('{0, 32'hFFFFFFFC, 2, 0, 32'h0,     32'h0,         1, 1, 0, 0,    4'h0, 32'h0,        0,  0});
    add('{0, 32'h1FFF,  0, 1, 32'h0,        32'h0,         0, 3, 1, 2047, 4'h0, 32'h0,        0,  0});
`ifdef RAM_ACC_MISALIGN_EN
    add('{0, 32'h11,    1, 0, 32'h0,        32'h00002233,  0, 3, 1, 4,    4'h0, 32'h0,        0,  0});
    add('{1, 32'h0E,    2, 0, 32'hAABBCCDD, 32'h0,         0, 5, 2, 3,    4'hC, 32'hCCDDAABB, 4,  4'h3});
    add('{0, 32'h0E,    2, 0, 32'h0,        32'hAABBCCDD,  0, 5, 2, 3,    4'h0, 32'h0,        4,  4'h0});
    add('{0, 32'h0F,    0, 0, 32'h0,        32'hFFFFFFCC,  0, 3, 1, 3,    4'h0, 32'h0,        0,  0});
    add('{1, 32'h1B,    1, 0, 32'h1234,     32'h0,         0, 5, 2, 6,    4'h8, 32'h34000012, 7,  4'h1});
    add('{0, 32'h1B,    1, 1, 32'h0,        32'h00001234,  0, 5, 2, 6,    4'h0, 32'h0,        7,  4'h0});
    add('{0, 32'h1FFE,  2, 0, 32'h0,        32'h0,         1, 1, 0, 0,    4'h0, 32'h0,        0,  0});
    add('{0, 32'h1FFF,  1, 0, 32'h0,        32'h0,         1, 1, 0, 0,    4'h0, 32'h0,        0,  0});
`else
    add('{0, 32'h0E,    2, 0, 32'h0,        32'h0,         1, 1, 0, 0,    4'h0, 32'h0,        0,  0});
    add('{0, 32'h11,    1, 0, 32'h0,        32'h0,         1, 1, 0, 0,    4'h0, 32'h0,        0,  0});
    add('{1, 32'h03,    1, 0, 32'h1234,     32'h0,         1, 1, 0, 0,    4'h0, 32'h0,        0,  0});
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst ram_en", 32'(ram_en), 32'd0);
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst ram_wem", 32'(ram_wem), 32'd0);
    chk("rst ram_addr", 32'(ram_addr), 32'd0);
    chk("rst ram_din", ram_din, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < nv; i++) run_vec(i, vecs[i]);

    // Reset asserted while the load sits in WAIT1
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = 2'b10;
    req_unsigned = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst acc1 ram_en", 32'(ram_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst ram_en", 32'(ram_en), 32'd0);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst ready_after", 32'(req_ready), 32'd1);
    blips = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid || ram_en) blips++;
    end
    chk("midrst no_activity", 32'(blips), 32'd0);

    // Back-to-back loads offered in each RESP cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = 2'b10;
    req_unsigned = 1'b0;
    ne = 0; nr = 0;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ram_en) begin
        if (ne < 4) en_cyc[ne] = c;
        ne++;
      end
      if (rsp_valid) begin
        if (nr < 4) rsp_cyc[nr] = c;
        nr++;
        chk($sformatf("b2b rdata%0d", nr), rsp_rdata, 32'hBEEF0000);
      end
      if (c == 7) req_valid = 1'b0;
    end
    chk("b2b en_count", 32'(ne), 32'd3);
    chk("b2b rsp_count", 32'(nr), 32'd3);
    if (ne == 3) begin
      chk("b2b en0", 32'(en_cyc[0]), 32'd1);
      chk("b2b en1", 32'(en_cyc[1]), 32'd4);
      chk("b2b en2", 32'(en_cyc[2]), 32'd7);
    end
    if (nr == 3) begin
      chk("b2b rsp0", 32'(rsp_cyc[0]), 32'd3);
      chk("b2b rsp1", 32'(rsp_cyc[1]), 32'd6);
      chk("b2b rsp2", 32'(rsp_cyc[2]), 32'd9);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Load/store access controller that sits directly upstream of the on-chip dual-port RAM. It drives one RAM port. It accepts byte-addressed core requests through a valid/ready handshake. It converts each request into word-addressed RAM cycles with byte-lane write masks, then aligns and sign- or zero-extends read data. Every accepted request gets exactly one single-cycle response pulse.

## Interface
- RAM_DEPTH, 2048, RAM depth in 32-bit words; AW = clogb2(RAM_DEPTH-1) is the RAM address width.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted; a transfer occurs when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned  in  1  on loads, zero-extend when 1 and sign-extend when 0.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was rejected and no RAM access occurred.
- ram_en, ram_we  out  1 each  RAM port enable and write enable.
- ram_wem  out  4  RAM byte write mask.
- ram_addr  out  AW  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data; valid the cycle after ram_en with ram_we=0.

## Operation
- States: IDLE, ACC1, WAIT1, ACC2, WAIT2, RESP.
- req_ready = !rst && (state==IDLE || state==RESP).
- On a transfer, latch the request and set o = req_addr[1:0] and W = req_addr[31:2].
- Error checks at accept time. rsp_err=1 and no RAM access for any of:
  - size 11;
  - W >= RAM_DEPTH;
  - a split access (see Configuration) with W+1 >= RAM_DEPTH; there is no wrap-around;
  - a misaligned access with the macro absent.
- An error request goes directly to RESP.
- Lane set L: byte → {o}; half → {o, o+1}; word → {o..o+3}, with lanes taken mod 4.
  - First access: word W, lanes in L with index ≥ o.
  - Second access: word W+1, lanes in L with index < o. It exists only when L wraps past lane 3.
- ACC1 / ACC2 drive, as registered outputs:
  - ram_en=1, ram_we=req_we, ram_addr=W or W+1;
  - ram_din = req_wdata rotated left by 8·o;
  - ram_wem = the first/second lane set when storing, 4'b0000 when loading.
- Outside ACC1 and ACC2, ram_en, ram_we and ram_wem are 0.
- WAIT1 / WAIT2 capture the lanes of ram_dout belonging to their access into a 32-bit assembly register.
- Load result = assembly register rotated right by 8·o, then truncated to size and extended per req_unsigned.
- Transitions:
  - IDLE → ACC1 on a good transfer.
  - ACC1 → WAIT1.
  - WAIT1 → ACC2 if split, else → RESP.
  - ACC2 → WAIT2 → RESP.
- RESP pulses rsp_valid. A transfer during RESP goes to ACC1 (or to RESP again on error); otherwise the FSM returns to IDLE.

## Timing
- Reset values: state IDLE; rsp_valid, rsp_err, ram_en and ram_we are 0; ram_wem, ram_addr, ram_din and rsp_rdata are 0.
- Reset mid-operation aborts the request with no response. ram_en is 0 from the cycle after rst is sampled.
- Transfer at cycle T:
  - Non-split access: ram_en in T+1, data captured in T+2, rsp_valid in T+3.
  - Split access: second ram_en in T+3, rsp_valid in T+5.
  - Error: rsp_valid with rsp_err=1 in T+1.
- Back-to-back: a transfer in the RESP cycle T+3 gives the next ram_en in T+4, so sustained throughput is one request per 3 cycles.
- Only one request is outstanding at a time. rsp_rdata and rsp_err hold their values while rsp_valid=1.

## Configuration
- RAM_ACC_MISALIGN_EN defined:
  - A halfword with o=3 and a word with o≠0 that straddle words are split into two RAM accesses.
  - A halfword with o=1 completes in one access.
- RAM_ACC_MISALIGN_EN undefined:
  - A halfword with addr[0]=1 or a word with addr[1:0]≠0 is rejected with rsp_err=1.
  - No ACC2 or WAIT2 logic is built.

## Test plan
- Store word 0x11223344 @0x10 → ram_wem=1111 and ram_addr=4 at T+1. Then load a byte with req_unsigned=0 @0x12 → rsp_rdata=0x00000022 at T+3.
- Store byte 0x80 @0x07, then load a signed byte @0x07 → 0xFFFFFF80. Load the same byte unsigned → 0x00000080.
- With the macro defined: store word 0xAABBCCDD @0x0E → ACC1 at addr 3 with wem=1100 and din=0xCCDDAABB; ACC2 at addr 4 with wem=0011. A load word @0x0E returns 0xAABBCCDD at T+5.
- With the macro undefined: load word @0x0E → rsp_err=1 at T+1 and ram_en never asserted. size=11 gives the same result in both builds.
- Addr = RAM_DEPTH·4 → rsp_err at T+1. With the macro defined, word @ (RAM_DEPTH·4−2) → rsp_err (no wrap).
- Assert rst during WAIT1 → no rsp_valid, ram_en=0, and req_ready=1 the cycle after rst deasserts. Back-to-back requests offered in the RESP cycle → ram_en every 3 cycles.
